// File: rtl/cnn_pkg.sv
// cnn_pkg: shared word width, per-layer map dimensions and the max-pool FSM state type.
package cnn_pkg;
    localparam int DATA_W    = 16;
    localparam int CONV1_DIM = 24;
    localparam int CONV1_CH  = 6;
    localparam int CONV2_DIM = 8;
    localparam int CONV2_CH  = 16;
    typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} maxpool_state_t;
endpackage

// File: rtl/maxpool_engine_if.sv
// maxpool_engine_if: conv RAM read port and pool RAM write port seen by the pooling engine.
interface maxpool_engine_if import cnn_pkg::*; #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    modport master (output rd_addr, wr_addr, wr_data, wr_en, input rd_data);
    modport slave  (input rd_addr, wr_addr, wr_data, wr_en, output rd_data);
endinterface

// File: rtl/maxpool_addr_gen.sv
// maxpool_addr_gen: channel/row/column/quad counters producing window read and pooled write addresses.
module maxpool_addr_gen import cnn_pkg::*; #(
    parameter int IN_DIM   = CONV1_DIM,
    parameter int CHANNELS = CONV1_CH,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              ld,
    input  logic              seq,
    input  logic              step,
    output logic [1:0]        q,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last
);
    localparam int OUT = IN_DIM / 2;
    localparam int CW  = $clog2(CHANNELS + 1);
    localparam int DW  = $clog2(OUT + 1);
    logic [CW-1:0]     c;
    logic [DW-1:0]     r, k;
    logic [1:0]        nq;
    logic [ADDR_W-1:0] base, off;
    always_comb begin
        nq   = seq ? q + 2'd1 : 2'd0;
        base = ADDR_W'(c) * ADDR_W'(IN_DIM * IN_DIM) + ADDR_W'(r) * ADDR_W'(2 * IN_DIM) + ADDR_W'({k, 1'b0});
        off  = (nq[1] ? ADDR_W'(IN_DIM) : '0) + ADDR_W'(nq[0]);
        last = c == CW'(CHANNELS - 1) && r == DW'(OUT - 1) && k == DW'(OUT - 1);
    end
    // addresses survive an abort; only the loop counters restart
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            wr_addr <= '0;
        end else begin
            if (ld) rd_addr <= base + off;
            if (step) wr_addr <= ADDR_W'(c) * ADDR_W'(OUT * OUT) + ADDR_W'(r) * ADDR_W'(OUT) + ADDR_W'(k);
        end
    end
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            c <= '0;
            r <= '0;
            k <= '0;
            q <= '0;
        end else begin
            if (ld) q <= nq;
            if (step) begin
                k <= k == DW'(OUT - 1) ? '0 : k + 1'b1;
                if (k == DW'(OUT - 1)) r <= r == DW'(OUT - 1) ? '0 : r + 1'b1;
                if (k == DW'(OUT - 1) && r == DW'(OUT - 1)) c <= c == CW'(CHANNELS - 1) ? '0 : c + 1'b1;
            end
        end
    end
endmodule

// File: rtl/maxpool_engine.sv
// maxpool_engine: 2x2 stride-2 max pooling from conv RAM into pool RAM.
// Define MAXPOOL_RELU_EN to clamp negative maxima to zero at the output.
module maxpool_engine import cnn_pkg::*; #(
    parameter int DATA_W   = cnn_pkg::DATA_W,
    parameter int IN_DIM   = CONV1_DIM,
    parameter int CHANNELS = CONV1_CH,
    parameter int ADDR_W   = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic rd_reset,
    input  logic wr_reset,
    maxpool_engine_if.master bus,
    output logic rd_done,
    output logic wr_done
);
    maxpool_state_t state, nstate;
    logic go, last;
    logic [1:0] q;
    logic signed [DATA_W-1:0] max_r, mx, res;
    assign go = enable && !rd_reset && !wr_reset;
    always_comb begin
        unique case (state)
            IDLE:    nstate = RD;
            RD:      nstate = q == 2'd3 ? LAST : RD;
            LAST:    nstate = WR;
            WR:      nstate = rd_done ? DONE : RD;
            default: nstate = DONE;
        endcase
        if (reset || !go) nstate = IDLE;
        mx = $signed(bus.rd_data) > max_r ? $signed(bus.rd_data) : max_r;
`ifdef MAXPOOL_RELU_EN
        res = mx[DATA_W-1] ? '0 : mx;
`else
        res = mx;
`endif
    end
    // rd_data lags rd_addr by one cycle, so quad q's data is consumed at q+1 (q=3 in LAST)
    always_ff @(posedge clk) begin
        state <= nstate;
        if (reset) begin
            max_r       <= '0;
            bus.wr_data <= '0;
            bus.wr_en   <= 1'b0;
            rd_done     <= 1'b0;
            wr_done     <= 1'b0;
        end else begin
            bus.wr_en <= go && state == LAST;
            rd_done   <= go && (rd_done || (state == RD && q == 2'd3 && last));
            wr_done   <= go && (wr_done || (state == WR && rd_done));
            if (state == RD && q != 2'd0) max_r <= q == 2'd1 ? $signed(bus.rd_data) : mx;
            if (state == LAST && go) bus.wr_data <= res;
        end
    end
    maxpool_addr_gen #(.IN_DIM(IN_DIM), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) u_gen (
        .clk     (clk),
        .reset   (reset),
        .clr     (!go),
        .ld      (nstate == RD),
        .seq     (state == RD),
        .step    (state == LAST && go),
        .q       (q),
        .rd_addr (bus.rd_addr),
        .wr_addr (bus.wr_addr),
        .last    (last)
    );
endmodule

// File: tb/tb_maxpool_engine.sv
// tb_maxpool_engine: directed checks of a default-size engine and a single-window (2x2, 1 channel) engine.
module tb_maxpool_engine;
    import cnn_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;
    logic en_b = 1'b0, rr_b = 1'b0, wrr_b = 1'b0, en_s = 1'b0;
    logic rd_done_b, wr_done_b, rd_done_s, wr_done_s;
    logic [15:0] smem [4];
    int tests = 0, fails = 0;
    int cnt1, rdc1, wdc1, bad1, cnt2, rdc2, wdc2, bad2;
    logic [31:0] sum1, sum2;
    logic [15:0] fd, la, ld;
    logic [15:0] neg_exp;

    maxpool_engine_if #(.DATA_W(16), .ADDR_W(12)) big ();
    maxpool_engine_if #(.DATA_W(16), .ADDR_W(4))  sm ();

    maxpool_engine #(.DATA_W(16), .IN_DIM(24), .CHANNELS(6), .ADDR_W(12)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .rd_reset(rr_b), .wr_reset(wrr_b),
        .bus(big), .rd_done(rd_done_b), .wr_done(wr_done_b));
    maxpool_engine #(.DATA_W(16), .IN_DIM(2), .CHANNELS(1), .ADDR_W(4)) dut_s (
        .clk(clk), .reset(reset), .enable(en_s), .rd_reset(1'b0), .wr_reset(1'b0),
        .bus(sm), .rd_done(rd_done_s), .wr_done(wr_done_s));

    // conv RAMs: big holds value = address, small holds a directed window
    always @(posedge clk) begin
        big.rd_data <= {4'b0, big.rd_addr};
        sm.rd_data  <= smem[sm.rd_addr[1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // window max of a value=address map: bottom-right element of window (c,r,k)
    function automatic logic [15:0] exp_max(input int a);
        int c, r, k;
        c = a / 144;
        r = (a % 144) / 12;
        k = a % 12;
        return 16'(c * 576 + (2 * r + 1) * 24 + 2 * k + 1);
    endfunction

    task automatic big_run(output int cnt, output logic [31:0] sum, output int rdc, output int wdc,
                           output int bad, output logic [15:0] first_d, output logic [15:0] last_a,
                           output logic [15:0] last_d);
        cnt = 0; sum = 0; rdc = -1; wdc = -1; bad = 0; first_d = 0; last_a = 0; last_d = 0;
        for (int t = 1; t <= 6000 && wdc < 0; t++) begin
            @(negedge clk);
            if (big.wr_en) begin
                if (int'(big.wr_addr) != cnt) bad++;
                if (big.wr_data !== exp_max(cnt)) bad++;
                if (cnt == 0) first_d = big.wr_data;
                last_a = {4'b0, big.wr_addr};
                last_d = big.wr_data;
                sum = sum * 31 + {4'b0, big.wr_addr, big.wr_data};
                cnt++;
            end
            if (rd_done_b && rdc < 0) rdc = t;
            if (wr_done_b && wdc < 0) wdc = t;
        end
    endtask

    task automatic small_win(input logic [15:0] a, b, c, d, input logic [15:0] exp, input string tag);
        en_s = 1'b0;
        @(negedge clk);
        smem[0] = a; smem[1] = b; smem[2] = c; smem[3] = d;
        en_s = 1'b1;
        repeat (6) @(negedge clk);
        chk({tag, "_wr_en"}, 32'(sm.wr_en), 32'd1);
        chk({tag, "_data"}, 32'(sm.wr_data), 32'(exp));
    endtask

    initial begin
`ifdef MAXPOOL_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hFFFD;
`endif
        smem[0] = 16'hFFFB; smem[1] = 16'hFFFD; smem[2] = 16'hFFF7; smem[3] = 16'hFFFC;
        repeat (3) @(negedge clk);
        chk("rst_rd_addr", 32'(big.rd_addr), 0);
        chk("rst_wr_addr", 32'(big.wr_addr), 0);
        chk("rst_wr_data", 32'(big.wr_data), 0);
        chk("rst_wr_en", 32'(big.wr_en), 0);
        chk("rst_rd_done", 32'(rd_done_b), 0);
        chk("rst_wr_done", 32'(wr_done_b), 0);

        reset = 1'b0;
        en_s = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t <= 4) chk("s_rd_addr", 32'(sm.rd_addr), 32'(t - 1));
            chk("s_wr_en", 32'(sm.wr_en), 32'(t == 6));
            chk("s_rd_done", 32'(rd_done_s), 32'(t >= 5));
            chk("s_wr_done", 32'(wr_done_s), 32'(t >= 7));
            if (t == 6) begin
                chk("s_wr_addr", 32'(sm.wr_addr), 0);
                chk("s_neg_max", 32'(sm.wr_data), 32'(neg_exp));
            end
        end
        small_win(16'd7, 16'd7, 16'd7, 16'd7, 16'd7, "s_equal");
        small_win(16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, "s_extreme");
        small_win(16'h8000, 16'h8000, 16'h8000, 16'h8001, 16'h8001, "s_minpair");
        en_s = 1'b0;

        en_b = 1'b1;
        big_run(cnt1, sum1, rdc1, wdc1, bad1, fd, la, ld);
        chk("b_wr_done_cycle", 32'(wdc1), 32'd5185);
        chk("b_rd_done_cycle", 32'(rdc1), 32'd5183);
        chk("b_write_count", 32'(cnt1), 32'd864);
        chk("b_bad_writes", 32'(bad1), 0);
        chk("b_first_data", 32'(fd), 32'd25);
        chk("b_last_addr", 32'(la), 32'd863);
        chk("b_last_data", 32'(ld), 32'd3455);
        repeat (3) @(negedge clk);
        chk("b_done_idle_wr_en", 32'(big.wr_en), 0);
        chk("b_done_hold", 32'({rd_done_b, wr_done_b}), 32'd3);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("b_reset_rd_done", 32'(rd_done_b), 0);
        chk("b_reset_wr_done", 32'(wr_done_b), 0);
        big_run(cnt2, sum2, rdc2, wdc2, bad2, fd, la, ld);
        chk("b_rerun_sum", sum2, sum1);
        chk("b_rerun_count", 32'(cnt2), 32'd864);
        chk("b_rerun_wr_done", 32'(wdc2), 32'd5185);

        en_b = 1'b0;
        @(negedge clk);
        en_b = 1'b1;
        repeat (100) @(negedge clk);
        rr_b = 1'b1;
        for (int t = 101; t <= 115; t++) begin
            @(negedge clk);
            chk("b_abort_wr_en", 32'(big.wr_en), 0);
        end
        rr_b = 1'b0;
        @(negedge clk);
        chk("b_restart_rd_addr", 32'(big.rd_addr), 0);
        repeat (5) @(negedge clk);
        chk("b_restart_wr_en", 32'(big.wr_en), 32'd1);
        chk("b_restart_wr_addr", 32'(big.wr_addr), 0);
        chk("b_restart_wr_data", 32'(big.wr_data), 32'd25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
